nlprg_period_chk: RTL and testbench

Synthesizable downstream monitor for the nlprg PRNG family (e.g. nlprg13). It consumes the generator's N-bit output stream and measures the sequence period, the number of valid samples until the first captured value recurs. It flags short period, overrun, stuck output and input starvation, and reports pass when the period equals the expected full length. It replaces end-of-sequence checks that are currently done only in the testbench, so the check can run on silicon/FPGA too.

---
 rtl/nlprg_chk_pkg.sv | 17 +
 rtl/nlprg_wdog.sv | 36 +++
 rtl/nlprg_period_chk.sv | 138 +++++++++++++
 tb/tb_nlprg_period_chk.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nlprg_chk_pkg.sv
// Shared types for the nlprg period checker: measurement FSM states and error codes.
package nlprg_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_SHORT  = 3'd1;
  localparam logic [2:0] ERR_OVER   = 3'd2;
  localparam logic [2:0] ERR_STUCK  = 3'd3;
  localparam logic [2:0] ERR_STARVE = 3'd4;

endpackage

// File: rtl/nlprg_wdog.sv
// Consecutive idle-cycle counter; expire is combinational and asserts on the WDOG-th idle cycle.
// No backpressure; WDOG=0 disables expiry entirely.
module nlprg_wdog #(
  parameter int WDOG = 64
) (
  input  logic ck,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CW = (WDOG > 1) ? $clog2(WDOG + 1) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  generate
    if (WDOG == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      // Fire while the WDOG-th idle cycle is being sampled, not one cycle later.
      assign expire = en && (cnt_q == CW'(WDOG - 1));
    end
  endgenerate

endmodule

// File: rtl/nlprg_period_chk.sv
// Measures the period of an nlprg output stream and flags short/overrun/stuck/starved runs.
// Registered outputs, done one edge after the terminating sample; input is never stalled.
module nlprg_period_chk
  import nlprg_chk_pkg::*;
#(
  parameter int N          = 13,
  parameter int EXP_PERIOD = 2**N,
  parameter int WDOG       = 64
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clr,
  input  logic         in_vld,
  input  logic [N-1:0] in_data,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   period,
  output logic [2:0]   err_code
);

  localparam logic [N:0] EXP_P = (N+1)'(EXP_PERIOD);

  state_t       state_q, state_d;
  logic [N-1:0] ref_q, ref_d;
  logic [N-1:0] prev_q, prev_d;
  logic [N:0]   cnt_q, cnt_d, cnt_nxt;
  logic [N:0]   period_q, period_d;
  logic [2:0]   err_q, err_d;
  logic         busy_q, done_q, pass_q;
  logic         wd_en, wd_clr, wd_exp;

  assign wd_en  = (state_q == RUN) && !in_vld;
  assign wd_clr = (state_q != RUN) || in_vld;

  nlprg_wdog #(.WDOG(WDOG)) u_wdog (
    .ck     (ck),
    .rst_n  (rst_n),
    .en     (wd_en),
    .clr    (wd_clr),
    .expire (wd_exp)
  );

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    err_d    = err_q;
    cnt_nxt  = cnt_q + 1'b1;

    if (clr) begin
      state_d  = IDLE;
      ref_d    = '0;
      prev_d   = '0;
      cnt_d    = '0;
      period_d = '0;
      err_d    = ERR_NONE;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = ARM;
        ARM: begin
          if (in_vld) begin
            ref_d   = in_data;
            prev_d  = in_data;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          // Recurrence outranks overrun and stuck so EXP_PERIOD==1 still terminates cleanly.
          if (in_vld) begin
            if (in_data == ref_q) begin
              period_d = cnt_nxt;
              err_d    = (cnt_nxt < EXP_P) ? ERR_SHORT : ERR_NONE;
              state_d  = DONE;
            end else if (cnt_nxt == EXP_P) begin
              period_d = cnt_nxt;
              err_d    = ERR_OVER;
              state_d  = DONE;
            end else if (in_data == prev_q) begin
              period_d = cnt_nxt;
              err_d    = ERR_STUCK;
              state_d  = DONE;
            end else begin
              cnt_d  = cnt_nxt;
              prev_d = in_data;
            end
          end else if (wd_exp) begin
            period_d = cnt_q;
            err_d    = ERR_STARVE;
            state_d  = DONE;
          end
        end
        DONE: begin
          if (start) begin
            state_d = ARM;
            err_d   = ERR_NONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ref_q    <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      err_q    <= ERR_NONE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      err_q    <= err_d;
      busy_q   <= (state_d == ARM) || (state_d == RUN);
      done_q   <= (state_d == DONE);
      pass_q   <= (state_d == DONE) && (err_d == ERR_NONE);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign period   = period_q;
  assign err_code = err_q;

endmodule

// File: tb/tb_nlprg_period_chk.sv
// Directed scenarios for nlprg_period_chk; expected results are queued at stimulus time
// and popped by a monitor each time done rises.
module tb_nlprg_period_chk;

  localparam int N   = 13;
  localparam int EXP = 8192;
  localparam int WD  = 64;

  logic         ck = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         clr = 1'b0;
  logic         in_vld = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         busy, done, pass;
  logic [N:0]   period;
  logic [2:0]   err_code;

  typedef struct packed {
    logic [2:0] err;
    logic [N:0] per;
    logic       pas;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic done_d = 1'b0;

  always #5 ck = ~ck;

  nlprg_period_chk #(.N(N), .EXP_PERIOD(EXP), .WDOG(WD)) dut (
    .ck       (ck),
    .rst_n    (rst_n),
    .start    (start),
    .clr      (clr),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .period   (period),
    .err_code (err_code)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Full-period 13-bit source (LCG, a=5 c=1) standing in for nlprg13: visits all 8192 states.
  function automatic logic [N-1:0] nxt(input logic [N-1:0] x);
    return x * 13'd5 + 13'd1;
  endfunction

  task automatic drive(input logic v, input logic [N-1:0] d, input logic s, input logic c);
    @(posedge ck);
    #1;
    in_vld  = v;
    in_data = d;
    start   = s;
    clr     = c;
  endtask

  task automatic smp(input logic [N-1:0] d);
    drive(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic gap();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic go();
    drive(1'b0, '0, 1'b1, 1'b0);
    gap();
  endtask

  task automatic push(input logic [2:0] e, input logic [N:0] p, input logic ps);
    exp_t t;
    t.err = e;
    t.per = p;
    t.pas = ps;
    exp_q.push_back(t);
  endtask

  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (!done && i < budget) begin
      @(posedge ck);
      #1;
      i++;
    end
    chk(name, int'(done), 1);
  endtask

  always @(negedge ck) begin
    exp_t e;
    if (done && !done_d) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("err_code", int'(err_code), int'(e.err));
        chk("period", int'(period), int'(e.per));
        chk("pass", int'(pass), int'(e.pas));
      end
    end
    done_d = done;
  end

  initial begin
    logic [N-1:0] x;
    int gp;
    int i;

    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_err", int'(err_code), 0);
    @(posedge ck);
    #1;
    rst_n = 1'b1;

    // Full-length sequence: 8193 samples, the last equals the first.
    push(3'd0, 14'd8192, 1'b1);
    go();
    chk("arm_busy", int'(busy), 1);
    x = 13'd123;
    for (int k = 0; k <= EXP; k++) begin
      smp(x);
      x = nxt(x);
    end
    gap();
    wait_done("s1_done", 4);
    chk("s1_busy_low", int'(busy), 0);

    // Short period: counter 0..4095 then 0 again; also checks start-from-DONE clears results.
    push(3'd1, 14'd4096, 1'b0);
    go();
    chk("restart_done_clr", int'(done), 0);
    chk("restart_pass_clr", int'(pass), 0);
    chk("restart_busy", int'(busy), 1);
    for (int k = 0; k <= 4096; k++) smp(13'(k % 4096));
    gap();
    wait_done("s2_done", 4);

    // Overrun: 0..8191 then 1.
    push(3'd2, 14'd8192, 1'b0);
    go();
    for (int k = 0; k < EXP; k++) smp(13'(k));
    smp(13'd1);
    gap();
    wait_done("s3_done", 4);

    // Stuck: 5,6,7,7 with exact done timing.
    push(3'd3, 14'd3, 1'b0);
    go();
    smp(13'd5);
    smp(13'd6);
    smp(13'd7);
    smp(13'd7);
    chk("s4_done_early", int'(done), 0);
    gap();
    chk("s4_done_edge", int'(done), 1);

    // Full-length sequence with random valid gaps shorter than the watchdog.
    push(3'd0, 14'd8192, 1'b1);
    go();
    x = 13'd77;
    gp = 0;
    i = 0;
    while (i <= EXP) begin
      if (gp < 8 && $urandom_range(0, 1) == 0) begin
        gap();
        gp++;
      end else begin
        smp(x);
        x = nxt(x);
        i++;
        gp = 0;
      end
    end
    gap();
    wait_done("s5_done", 4);

    // Starvation: 10 samples (cnt=9) then in_vld held low for 64 sampled cycles.
    push(3'd4, 14'd9, 1'b0);
    go();
    x = 13'd300;
    for (int k = 0; k < 10; k++) begin
      smp(x);
      x = nxt(x);
    end
    for (int k = 0; k < 64; k++) gap();
    chk("s6_no_early_starve", int'(done), 0);
    gap();
    chk("s6_starve_edge", int'(done), 1);

    // start while busy must not restart the measurement.
    push(3'd3, 14'd4, 1'b0);
    go();
    smp(13'd40);
    smp(13'd41);
    drive(1'b1, 13'd42, 1'b1, 1'b0);
    smp(13'd43);
    smp(13'd43);
    gap();
    wait_done("s7_done", 4);

    // clr during RUN returns to IDLE on the next edge and clears results.
    go();
    for (int k = 0; k < 5; k++) smp(13'(100 + k));
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("clr_not_yet", int'(busy), 1);
    gap();
    chk("clr_busy", int'(busy), 0);
    chk("clr_done", int'(done), 0);
    chk("clr_period", int'(period), 0);
    smp(13'd5);
    smp(13'd5);
    gap();
    chk("idle_ignores_vld", int'(busy), 0);

    // Asynchronous reset mid-run.
    go();
    for (int k = 0; k < 6; k++) smp(13'(200 + k));
    #2;
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_period", int'(period), 0);
    @(posedge ck);
    #1;
    rst_n = 1'b1;
    gap();
    chk("postrst_busy", int'(busy), 0);

    // Measurement after reset: ref 9, then 3, then 9 again.
    push(3'd1, 14'd2, 1'b0);
    go();
    smp(13'd9);
    smp(13'd3);
    smp(13'd9);
    gap();
    wait_done("s10_done", 4);

    repeat (3) @(posedge ck);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
